// File: rtl/smbs_frame_rx.sv
// Serial frame receiver: start, bank[1:0], led[1:0], data, even parity, stop.
// Drives the LED-bank demultiplexer's SI/PL inputs and holds them between good frames.
module smbs_frame_rx #(
    parameter logic STOP_LEVEL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic       SI,
    output logic [5:0] PL,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, BANK, LED, DATA, PAR, STOP} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       bit_cnt;
    logic [1:0] bank_sr;
    logic [1:0] led_sr;
    logic       data_r;
    logic       par_acc;
    logic       good;
    logic [3:0] bank_onehot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (serial_in) state_nxt = BANK;
            BANK:    if (bit_cnt)   state_nxt = LED;
            LED:     if (bit_cnt)   state_nxt = DATA;
            DATA:    state_nxt = PAR;
            PAR:     state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // par_acc already holds bank^led^data^par when the stop bit is on the line
    always_comb begin
        busy        = (state != IDLE);
        good        = (state == STOP) && !par_acc && (serial_in == STOP_LEVEL);
        bank_onehot = 4'b0001 << bank_sr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= 1'b0;
            bank_sr <= '0;
            led_sr  <= '0;
            data_r  <= 1'b0;
            par_acc <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt <= 1'b0;
                    par_acc <= 1'b0;
                end
                BANK: begin
                    bank_sr <= {bank_sr[0], serial_in};
                    bit_cnt <= ~bit_cnt;
                    par_acc <= par_acc ^ serial_in;
                end
                LED: begin
                    led_sr  <= {led_sr[0], serial_in};
                    bit_cnt <= ~bit_cnt;
                    par_acc <= par_acc ^ serial_in;
                end
                DATA: begin
                    data_r  <= serial_in;
                    par_acc <= par_acc ^ serial_in;
                end
                PAR:     par_acc <= par_acc ^ serial_in;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            SI          <= 1'b0;
            PL          <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (state == STOP) begin
                if (good) begin
                    PL          <= {led_sr, bank_onehot};
                    SI          <= data_r;
                    frame_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_smbs_frame_rx.sv
// Directed bench for smbs_frame_rx: frame-level reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_smbs_frame_rx;
    localparam logic STOP_LEVEL = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_in = 1'b0;
    logic       SI;
    logic [5:0] PL;
    logic       frame_valid;
    logic       frame_err;
    logic       busy;

    int unsigned tests = 0;
    int unsigned fails = 0;

    smbs_frame_rx #(.STOP_LEVEL(STOP_LEVEL)) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .SI         (SI),
        .PL         (PL),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collect the 7 bits following a start bit, then decode the frame.
    bit         in_frame = 0;
    bit         q[$];
    logic       m_si = 0;
    logic [5:0] m_pl = '0;
    logic       m_valid = 0;
    logic       m_err = 0;
    int unsigned cycle = 0;
    int unsigned busy_run = 0;
    int unsigned pulse_cnt = 0;
    int unsigned valid_cycles[$];

    always @(posedge clk) begin
        logic s_in, s_rst;
        logic [1:0] bank, led;
        logic [3:0] onehot;
        s_in  = serial_in;
        s_rst = rst;
        #1;
        cycle++;
        m_valid = 0;
        m_err   = 0;
        if (s_rst) begin
            in_frame = 0;
            q.delete();
            m_si = 0;
            m_pl = '0;
        end else if (!in_frame) begin
            if (s_in) begin
                in_frame = 1;
                q.delete();
            end
        end else begin
            q.push_back(s_in);
            if (q.size() == 7) begin
                bank = {q[0], q[1]};
                led  = {q[2], q[3]};
                if (((q[0] ^ q[1] ^ q[2] ^ q[3] ^ q[4] ^ q[5]) == 1'b0) && (q[6] == STOP_LEVEL)) begin
                    onehot  = 4'b0001 << bank;
                    m_pl    = {led, onehot};
                    m_si    = q[4];
                    m_valid = 1;
                end else begin
                    m_err = 1;
                end
                in_frame = 0;
            end
        end
        chk("model_PL", PL, m_pl);
        chk("model_SI", SI, m_si);
        chk("model_valid", frame_valid, m_valid);
        chk("model_err", frame_err, m_err);
        chk("model_busy", busy, in_frame);
        if (busy) busy_run++;
        if (frame_valid || frame_err) pulse_cnt++;
        if (frame_valid) valid_cycles.push_back(cycle);
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        serial_in = b;
    endtask

    task automatic send_frame(input logic [7:0] f);
        for (int i = 7; i >= 0; i--) send_bit(f[i]);
    endtask

    // Moves to just after the edge that samples the last driven bit.
    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) send_bit(1'b0);
    endtask

    initial begin
        // Reset and idle line
        #1;
        chk("rst_PL", PL, 6'b000000);
        chk("rst_SI", SI, 1'b0);
        chk("rst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(20);
        after_edge();
        chk("idle_PL", PL, 6'b000000);
        chk("idle_SI", SI, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_pulses", pulse_cnt, 0);

        // Good frame: bank 2, led 1, data 1, par 1
        busy_run = 0;
        send_frame(8'b1100_1110);
        after_edge();
        chk("good_PL", PL, 6'b010100);
        chk("good_SI", SI, 1'b1);
        chk("good_valid", frame_valid, 1'b1);
        chk("good_err", frame_err, 1'b0);
        chk("good_busy_len", busy_run, 7);
        send_bit(1'b0);
        after_edge();
        chk("good_valid_1cyc", frame_valid, 1'b0);

        // Same frame, bad parity
        send_frame(8'b1100_1100);
        after_edge();
        chk("par_err", frame_err, 1'b1);
        chk("par_valid", frame_valid, 1'b0);
        chk("par_PL_hold", PL, 6'b010100);
        chk("par_SI_hold", SI, 1'b1);
        idle(2);

        // Bad stop bit: bank 0, led 3, data 0, par 0, stop 1
        send_frame(8'b1001_1001);
        after_edge();
        chk("stop_err", frame_err, 1'b1);
        chk("stop_PL_hold", PL, 6'b010100);
        send_bit(1'b0);
        after_edge();
        chk("stop_no_restart", busy, 1'b0);
        idle(2);

        // Back-to-back: bank 3 led 0 data 1 par 1; bank 0 led 2 data 0 par 1
        valid_cycles.delete();
        send_frame(8'b1110_0110);
        after_edge();
        chk("b2b1_PL", PL, 6'b001000);
        chk("b2b1_SI", SI, 1'b1);
        send_frame(8'b1001_0010);
        after_edge();
        chk("b2b2_PL", PL, 6'b100001);
        chk("b2b2_SI", SI, 1'b0);
        chk("b2b_count", valid_cycles.size(), 2);
        if (valid_cycles.size() == 2)
            chk("b2b_spacing", valid_cycles[1] - valid_cycles[0], 8);
        idle(3);

        // Reset during DATA bit, then a clean frame: bank 1, led 2, data 1, par 1
        pulse_cnt = 0;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_PL", PL, 6'b000000);
        chk("arst_SI", SI, 1'b0);
        chk("arst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        serial_in = 1'b0;
        idle(2);
        after_edge();
        chk("arst_no_pulse", pulse_cnt, 0);
        send_frame(8'b1011_0110);
        after_edge();
        chk("post_PL", PL, 6'b100010);
        chk("post_SI", SI, 1'b1);
        chk("post_valid", frame_valid, 1'b1);
        idle(4);
        after_edge();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
